dmem_arbiter: RTL

- Shares the single data-memory port (rammanager interface: 4-bit byte write enables, 32-bit address/data, combinational read) between the CPU MEM stage and a DMA/boot-loader port.
- CPU has priority. A starvation counter guarantees the DMA port a slot.
- Drives a stall to the hazard unit when the MEM-stage access loses arbitration.
- Keeps a saturating stall-cycle statistic.

---
 rtl/dmem_arbiter_if.sv | 29 ++
 rtl/dmem_arbiter.sv | 54 +++++
 2 files changed

// File: rtl/dmem_arbiter_if.sv
// dmem_arbiter_if: CPU, DMA and memory-side signals of the shared data-memory port.
interface dmem_arbiter_if #(parameter int CNT_W = 16);
  logic             cpu_req;
  logic [3:0]       cpu_we;
  logic [31:0]      cpu_addr;
  logic [31:0]      cpu_wdata;
  logic [31:0]      cpu_rdata;
  logic             cpu_stall;
  logic             dma_req;
  logic [3:0]       dma_we;
  logic [31:0]      dma_addr;
  logic [31:0]      dma_wdata;
  logic             dma_gnt;
  logic             dma_rvalid;
  logic [31:0]      dma_rdata;
  logic [3:0]       mem_we;
  logic [31:0]      mem_addr;
  logic [31:0]      mem_wdata;
  logic [31:0]      mem_rdata;
  logic [CNT_W-1:0] stall_count;
  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata, dma_req, dma_we, dma_addr, dma_wdata, mem_rdata,
    input  cpu_rdata, cpu_stall, dma_gnt, dma_rvalid, dma_rdata, mem_we, mem_addr, mem_wdata, stall_count
  );
  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata, dma_req, dma_we, dma_addr, dma_wdata, mem_rdata,
    output cpu_rdata, cpu_stall, dma_gnt, dma_rvalid, dma_rdata, mem_we, mem_addr, mem_wdata, stall_count
  );
endinterface

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: CPU-priority arbiter for the data-memory port with a DMA starvation guard.
module dmem_arbiter #(
  parameter int STARVE_LIMIT = 4,
  parameter int CNT_W        = 16
) (
  input logic            clk,
  input logic            rst_n,
  dmem_arbiter_if.slave  bus
);
  localparam logic [0:0] CPU_PRI = 1'b0;
  localparam logic [0:0] DMA_PRI = 1'b1;
  logic [0:0]       state;
  logic [7:0]       starve;
  logic [CNT_W-1:0] cnt;
  logic             rvalid;
  logic [31:0]      rdata;
  logic             dma_own;
  logic             cpu_own;
  logic             dma_blocked;
  logic             starved;
  logic             dma_rd;
  always_comb begin
    dma_own     = bus.dma_req & (state == DMA_PRI | ~bus.cpu_req);
    cpu_own     = bus.cpu_req & ~dma_own;
    dma_blocked = bus.dma_req & cpu_own;
    starved     = dma_blocked & ({1'b0, starve} + 9'd1 >= 9'(STARVE_LIMIT));
    dma_rd      = dma_own & ~|bus.dma_we;
  end
  // An idle cycle drives zeros so memory never sees a stray write enable.
  assign bus.mem_we      = dma_own ? bus.dma_we    : cpu_own ? bus.cpu_we    : 4'h0;
  assign bus.mem_addr    = dma_own ? bus.dma_addr  : cpu_own ? bus.cpu_addr  : 32'h0;
  assign bus.mem_wdata   = dma_own ? bus.dma_wdata : cpu_own ? bus.cpu_wdata : 32'h0;
  assign bus.cpu_rdata   = bus.mem_rdata;
  assign bus.cpu_stall   = bus.cpu_req & ~cpu_own;
  assign bus.dma_gnt     = dma_own;
  assign bus.dma_rvalid  = rvalid;
  assign bus.dma_rdata   = rdata;
  assign bus.stall_count = cnt;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= CPU_PRI;
      starve <= 8'd0;
      cnt    <= '0;
      rvalid <= 1'b0;
      rdata  <= 32'h0;
    end else begin
      state  <= starved ? DMA_PRI : CPU_PRI;
      starve <= (dma_blocked & ~starved) ? starve + 8'd1 : 8'd0;
      rvalid <= dma_rd;
      if (dma_rd) rdata <= bus.mem_rdata;
      if (bus.cpu_stall & ~&cnt) cnt <= cnt + CNT_W'(1);
    end
  end
endmodule
